// File: rtl/fetch_pc_ctrl_if.sv
// rtl/fetch_pc_ctrl_if.sv - fetch PC controller signal bundle (redirect, imem handshake, downstream valid/stall)
// master is the controller side, slave is the surrounding pipeline/memory side.
interface fetch_pc_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  pc_src;
  logic [DATA_WIDTH-1:0] branch_base;
  logic [DATA_WIDTH-1:0] imm_op;
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_ready;
  logic                  instr_valid;
  logic                  stall;
  logic [DATA_WIDTH-1:0] pc;
  logic                  misalign_err;

  modport master (
    input  pc_src, branch_base, imm_op, imem_ready, stall,
    output imem_req, imem_addr, instr_valid, pc, misalign_err
  );

  modport slave (
    output pc_src, branch_base, imm_op, imem_ready, stall,
    input  imem_req, imem_addr, instr_valid, pc, misalign_err
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// rtl/fetch_pc_ctrl.sv - instruction fetch PC controller with deferred branch redirect
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirect targets halt the block and set misalign_err.
module fetch_pc_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input logic              clk,
  input logic              rst,
  fetch_pc_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);

  state_t                state_q, state_nxt;
  logic [DATA_WIDTH-1:0] pc_q, pc_nxt;
  logic [DATA_WIDTH-1:0] redir_q, redir_nxt;
  logic                  pending_q, pending_nxt;
  logic                  redir_mis_q, redir_mis_nxt;
  logic                  err_q, err_nxt;

  logic [DATA_WIDTH-1:0] target_sum;
  logic [DATA_WIDTH-1:0] target;
  logic                  target_mis;

  assign target_sum = bus.branch_base + bus.imm_op;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign target     = target_sum;
  assign target_mis = |target_sum[1:0];
`else
  assign target     = target_sum & ALIGN_MASK;
  assign target_mis = 1'b0;
`endif

  always_comb begin
    state_nxt     = state_q;
    pc_nxt        = pc_q;
    redir_nxt     = redir_q;
    pending_nxt   = pending_q;
    redir_mis_nxt = redir_mis_q;
    err_nxt       = err_q;
    case (state_q)
      BOOT: begin
        state_nxt = FETCH;
        if (bus.pc_src) begin
          if (target_mis) begin
            state_nxt = HALT;
            err_nxt   = 1'b1;
          end else begin
            pc_nxt = target;
          end
        end
      end
      FETCH: begin
        if (bus.imem_ready) begin
          // A same-cycle redirect is newer than any latched one, so it wins.
          pending_nxt = 1'b0;
          if (bus.pc_src) begin
            if (target_mis) begin
              state_nxt = HALT;
              err_nxt   = 1'b1;
            end else begin
              pc_nxt = target;
            end
          end else if (pending_q) begin
            if (redir_mis_q) begin
              state_nxt = HALT;
              err_nxt   = 1'b1;
            end else begin
              pc_nxt = redir_q;
            end
          end else begin
            state_nxt = VALID;
          end
        end else if (bus.pc_src) begin
          redir_nxt     = target;
          redir_mis_nxt = target_mis;
          pending_nxt   = 1'b1;
        end
      end
      VALID: begin
        if (bus.pc_src) begin
          if (target_mis) begin
            state_nxt = HALT;
            err_nxt   = 1'b1;
          end else begin
            pc_nxt    = target;
            state_nxt = FETCH;
          end
        end else if (!bus.stall) begin
          pc_nxt    = pc_q + PC_STEP;
          state_nxt = FETCH;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      redir_q     <= RESET_PC;
      pending_q   <= 1'b0;
      redir_mis_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      pc_q        <= pc_nxt;
      redir_q     <= redir_nxt;
      pending_q   <= pending_nxt;
      redir_mis_q <= redir_mis_nxt;
      err_q       <= err_nxt;
    end
  end

  assign bus.imem_req     = (state_q == FETCH);
  assign bus.imem_addr    = pc_q;
  assign bus.instr_valid  = (state_q == VALID);
  assign bus.pc           = pc_q;
  assign bus.misalign_err = err_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb/tb_fetch_pc_ctrl.sv - self-checking bench for fetch_pc_ctrl (model compare plus directed literal checks)
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [31:0] BOOT_IMM = 32'h0;
`else
  localparam logic [31:0] BOOT_IMM = 32'h3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_pc_ctrl_if #(.DATA_WIDTH(32)) bus ();

  fetch_pc_ctrl #(.DATA_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: where the fetch is, what pc is, and redirects awaiting the response.
  localparam int PH_BOOT = 0, PH_FETCH = 1, PH_VALID = 2;
  int          m_phase = PH_BOOT;
  logic [31:0] m_pc    = RESET_PC;
  logic [31:0] m_redir [$];
  logic [31:0] consumed [$];

  function automatic logic [31:0] branch_target(input logic [31:0] b, input logic [31:0] i);
    logic [31:0] t;
    t = b + i;
`ifndef FETCH_MISALIGN_CHECK_EN
    t = {t[31:2], 2'b00};
`endif
    return t;
  endfunction

  always @(posedge clk) begin
    if (!rst && bus.instr_valid && !bus.stall)
      consumed.push_back(bus.pc);
    if (rst) begin
      m_phase = PH_BOOT;
      m_pc    = RESET_PC;
      m_redir.delete();
    end else begin
      case (m_phase)
        PH_BOOT: begin
          if (bus.pc_src) m_pc = branch_target(bus.branch_base, bus.imm_op);
          m_phase = PH_FETCH;
        end
        PH_FETCH: begin
          if (bus.imem_ready) begin
            if (bus.pc_src) m_pc = branch_target(bus.branch_base, bus.imm_op);
            else if (m_redir.size() != 0) m_pc = m_redir[$];
            else m_phase = PH_VALID;
            m_redir.delete();
          end else if (bus.pc_src) begin
            m_redir.push_back(branch_target(bus.branch_base, bus.imm_op));
          end
        end
        default: begin
          if (bus.pc_src) begin
            m_pc    = branch_target(bus.branch_base, bus.imm_op);
            m_phase = PH_FETCH;
          end else if (!bus.stall) begin
            m_pc    = m_pc + 32'd4;
            m_phase = PH_FETCH;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_imem_req", {31'b0, bus.imem_req}, {31'b0, m_phase == PH_FETCH});
      if (bus.imem_req) check("model_imem_addr", bus.imem_addr, m_pc);
      check("model_instr_valid", {31'b0, bus.instr_valid}, {31'b0, m_phase == PH_VALID});
      check("model_pc", bus.pc, m_pc);
      check("model_misalign_err", {31'b0, bus.misalign_err}, 32'h0);
    end
  end

  task automatic wait_valid(input logic [31:0] addr);
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.instr_valid && bus.pc == addr) begin
        found = 1'b1;
        break;
      end
    end
    check($sformatf("wait_valid_%h", addr), {31'b0, found}, 32'h1);
  endtask

  initial begin
    int hit20;
    bus.pc_src      = 1'b0;
    bus.branch_base = '0;
    bus.imm_op      = '0;
    bus.imem_ready  = 1'b0;
    bus.stall       = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_imem_req", {31'b0, bus.imem_req}, 32'h0);
    check("rst_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    check("rst_pc", bus.pc, 32'h0);
    check("rst_misalign_err", {31'b0, bus.misalign_err}, 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    bus.imem_ready = 1'b1;

    // Sequential fetch, then a 3-cycle stall at 0x8.
    @(negedge clk);
    check("boot_first_addr", bus.imem_addr, 32'h0);
    wait_valid(32'h8);
    bus.stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_pc", bus.pc, 32'h8);
      check("stall_valid", {31'b0, bus.instr_valid}, 32'h1);
    end
    bus.stall = 1'b0;
    @(negedge clk);
    check("after_stall_addr", bus.imem_addr, 32'hC);
    check("consumed_count", consumed.size(), 3);
    check("consumed_0", consumed[0], 32'h0);
    check("consumed_1", consumed[1], 32'h4);
    check("consumed_2", consumed[2], 32'h8);

    // Backward branch from VALID at 0x10 wraps to 0x0; redirect outranks stall.
    wait_valid(32'h10);
    bus.pc_src = 1'b1; bus.branch_base = 32'h10; bus.imm_op = 32'hFFFF_FFF0; bus.stall = 1'b1;
    @(negedge clk);
    bus.pc_src = 1'b0; bus.stall = 1'b0;
    check("branch_pc", bus.pc, 32'h0);
    check("branch_valid", {31'b0, bus.instr_valid}, 32'h0);
    check("branch_addr", bus.imem_addr, 32'h0);

    // Two redirects during an outstanding fetch at 0x20; newest wins, 0x20 discarded.
    wait_valid(32'h1C);
    bus.imem_ready = 1'b0;
    @(negedge clk);
    check("hold_addr_20", bus.imem_addr, 32'h20);
    bus.pc_src = 1'b1; bus.branch_base = 32'h100; bus.imm_op = 32'h0;
    @(negedge clk);
    bus.branch_base = 32'h200;
    @(negedge clk);
    bus.pc_src = 1'b0; bus.imem_ready = 1'b1;
    @(negedge clk);
    check("redir_req", {31'b0, bus.imem_req}, 32'h1);
    check("redir_addr", bus.imem_addr, 32'h200);
    check("redir_no_valid", {31'b0, bus.instr_valid}, 32'h0);
    wait_valid(32'h200);
    hit20 = 0;
    foreach (consumed[i]) if (consumed[i] == 32'h20) hit20++;
    check("no_consume_20", hit20, 0);

    // PC wrap at the top of the address space.
    bus.pc_src = 1'b1; bus.branch_base = 32'hFFFF_FF00; bus.imm_op = 32'hFC;
    @(negedge clk);
    bus.pc_src = 1'b0;
    check("jump_top_pc", bus.pc, 32'hFFFF_FFFC);
    wait_valid(32'hFFFF_FFFC);
    @(negedge clk);
    check("wrap_pc", bus.pc, 32'h0);
    check("wrap_addr", bus.imem_addr, 32'h0);

    // Reset in mid-FETCH with a response strobing, then a redirect straight out of BOOT.
    wait_valid(32'h4);
    bus.imem_ready = 1'b0;
    @(negedge clk);
    check("pre_rst_addr", bus.imem_addr, 32'h8);
    rst = 1'b1; bus.imem_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_pc", bus.pc, RESET_PC);
    check("mid_rst_req", {31'b0, bus.imem_req}, 32'h0);
    check("mid_rst_valid", {31'b0, bus.instr_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus.pc_src = 1'b1; bus.branch_base = 32'h40; bus.imm_op = BOOT_IMM;
    @(negedge clk);
    bus.pc_src = 1'b0;
    check("boot_redir_pc", bus.pc, 32'h40);
    check("boot_redir_addr", bus.imem_addr, 32'h40);
    wait_valid(32'h40);

`ifdef FETCH_MISALIGN_CHECK_EN
    chk_en = 1'b0;
    bus.pc_src = 1'b1; bus.branch_base = 32'h100; bus.imm_op = 32'h2;
    @(negedge clk);
    bus.pc_src = 1'b0;
    repeat (3) begin
      check("mis_err", {31'b0, bus.misalign_err}, 32'h1);
      check("mis_req", {31'b0, bus.imem_req}, 32'h0);
      check("mis_pc", bus.pc, 32'h40);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("mis_rst_err", {31'b0, bus.misalign_err}, 32'h0);
    check("mis_rst_pc", bus.pc, RESET_PC);
    rst = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
